// File: rtl/cam_pkg.sv
// Shared constants, FSM state type and max-index helper for the account CAM.
package cam_pkg;

    localparam int unsigned KEY_W  = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cam_state_t;

    // Highest populated index after a write lands at wr_addr.
    function automatic logic [ADDR_W-1:0] next_max_add(
        input logic              is_empty,
        input logic [ADDR_W-1:0] cur_max,
        input logic [ADDR_W-1:0] wr_addr
    );
        return (is_empty || (wr_addr > cur_max)) ? wr_addr : cur_max;
    endfunction

endpackage

// File: rtl/account_cam_if.sv
// Bus between the control FSM (master) and the account CAM (slave).
//   write side : cam_write_en, write_addr, write_key
//   search side: cam_start, search_key
//   results    : match, match_addr, search_done, busy, max_add, empty, write_drop
interface account_cam_if;
    import cam_pkg::*;

    logic              cam_write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [KEY_W-1:0]  write_key;
    logic              cam_start;
    logic [KEY_W-1:0]  search_key;
    logic              match;
    logic [ADDR_W-1:0] match_addr;
    logic              search_done;
    logic              busy;
    logic [ADDR_W-1:0] max_add;
    logic              empty;
    logic              write_drop;

    modport master (
        output cam_write_en, write_addr, write_key, cam_start, search_key,
        input  match, match_addr, search_done, busy, max_add, empty, write_drop
    );

    modport slave (
        input  cam_write_en, write_addr, write_key, cam_start, search_key,
        output match, match_addr, search_done, busy, max_add, empty, write_drop
    );

endinterface

// File: rtl/cam_entry_array.sv
// Key/valid storage for the account CAM with one write port, one
// combinational indexed read port, and highest-index / empty tracking.
//   clk, rst          : clock, synchronous active-high reset
//   we, waddr, wkey   : write port (caller gates we to legal cycles)
//   raddr             : read index
//   rd_key_c, rd_valid_c : combinational read data
//   max_add, empty    : registered occupancy summary
module cam_entry_array
    import cam_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [KEY_W-1:0]  wkey,
    input  logic [ADDR_W-1:0] raddr,
    output logic [KEY_W-1:0]  rd_key_c,
    output logic              rd_valid_c,
    output logic [ADDR_W-1:0] max_add,
    output logic              empty
);

    logic [KEY_W-1:0] key_mem [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Key storage is intentionally not reset; valid bits gate every read.
    always_ff @(posedge clk) begin
        if (we) begin
            key_mem[waddr] <= wkey;
        end
    end

    // Valid bits and occupancy summary.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            max_add <= '0;
            empty   <= 1'b1;
        end else if (we) begin
            valid_q[waddr] <= 1'b1;
            max_add        <= next_max_add(empty, max_add, waddr);
            empty          <= 1'b0;
        end
    end

    assign rd_key_c   = key_mem[raddr];
    assign rd_valid_c = valid_q[raddr];

endmodule

// File: rtl/account_cam.sv
// Sequential-search CAM for account identifiers. Writes land only in IDLE;
// a search walks entries 0..max_add and stops on the first hit, so the
// lowest matching index wins.
//   clk, rst : clock, synchronous active-high reset
//   bus      : account_cam_if.slave (write port, search request, results)
module account_cam
    import cam_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    account_cam_if.slave  bus
);

    cam_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              match_q, match_d;
    logic [ADDR_W-1:0] match_addr_q, match_addr_d;
    logic              search_done_q, search_done_d;
    logic              busy_q, busy_d;
    logic              write_drop_q, write_drop_d;

    logic              wr_en_c;
    logic [KEY_W-1:0]  rd_key_c;
    logic              rd_valid_c;
    logic [ADDR_W-1:0] max_add;
    logic              empty;
    logic              hit_c;
    logic              last_c;

    assign wr_en_c = bus.cam_write_en && (state_q == IDLE);

    cam_entry_array u_entries (
        .clk        (clk),
        .rst        (rst),
        .we         (wr_en_c),
        .waddr      (bus.write_addr),
        .wkey       (bus.write_key),
        .raddr      (idx_q),
        .rd_key_c   (rd_key_c),
        .rd_valid_c (rd_valid_c),
        .max_add    (max_add),
        .empty      (empty)
    );

    assign hit_c  = rd_valid_c && (rd_key_c == key_q);
    // max_add only moves on IDLE writes, so it is stable for a whole scan.
    assign last_c = (idx_q == max_add);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            key_q         <= '0;
            match_q       <= 1'b0;
            match_addr_q  <= '0;
            search_done_q <= 1'b0;
            busy_q        <= 1'b0;
            write_drop_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            key_q         <= key_d;
            match_q       <= match_d;
            match_addr_q  <= match_addr_d;
            search_done_q <= search_done_d;
            busy_q        <= busy_d;
            write_drop_q  <= write_drop_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cam_start) state_d = SCAN;
            SCAN:    if (hit_c || last_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the datapath and output registers.
    always_comb begin
        idx_d         = idx_q;
        key_d         = key_q;
        match_d       = match_q;
        match_addr_d  = match_addr_q;
        search_done_d = (state_d == DONE);
        busy_d        = (state_d != IDLE);
        write_drop_d  = bus.cam_write_en && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.cam_start) begin
                    key_d        = bus.search_key;
                    idx_d        = '0;
                    match_d      = 1'b0;
                    match_addr_d = '0;
                end
            end
            SCAN: begin
                if (hit_c) begin
                    match_d      = 1'b1;
                    match_addr_d = idx_q;
                end else if (last_c) begin
                    match_d      = 1'b0;
                end else begin
                    idx_d        = idx_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.match       = match_q;
    assign bus.match_addr  = match_addr_q;
    assign bus.search_done = search_done_q;
    assign bus.busy        = busy_q;
    assign bus.max_add     = max_add;
    assign bus.empty       = empty;
    assign bus.write_drop  = write_drop_q;

endmodule

// File: tb/tb_account_cam.sv
// Self-checking bench for account_cam: directed vector table, hand-written
// corner sequences, and randomized traffic against an array-based model.
module tb_account_cam;
    import cam_pkg::*;

    logic clk;
    logic rst;
    account_cam_if ifc ();

    account_cam dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: plain arrays of stored keys and valid flags.
    logic [31:0] mkey   [16];
    bit          mvalid [16];
    int          mmax;
    bit          mempty;

    typedef enum {OP_RST, OP_WR, OP_SRCH} op_e;
    typedef struct {
        op_e         op;
        int          addr;
        logic [31:0] key;
        bit          em;
        int          ea;
        int          elat;
        int          emax;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mvalid[i] = 0;
        mmax   = 0;
        mempty = 1;
    endfunction

    function automatic void model_write(input int a, input logic [31:0] k);
        mkey[a]   = k;
        mvalid[a] = 1;
        if (mempty || a > mmax) mmax = a;
        mempty = 0;
    endfunction

    // Lowest valid index holding k within 0..mmax; latency counts from the
    // cycle cam_start is presented to the cycle search_done is seen.
    function automatic void model_search(input logic [31:0] k, output bit m,
                                         output int a, output int lat);
        m   = 0;
        a   = 0;
        lat = mmax + 2;
        for (int i = 0; i <= mmax; i++) begin
            if (!m && mvalid[i] && mkey[i] == k) begin
                m   = 1;
                a   = i;
                lat = i + 2;
            end
        end
    endfunction

    task automatic idle_inputs();
        ifc.cam_write_en = 0;
        ifc.write_addr   = '0;
        ifc.write_key    = '0;
        ifc.cam_start    = 0;
        ifc.search_key   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        check("rst match", ifc.match, 0);
        check("rst match_addr", ifc.match_addr, 0);
        check("rst empty", ifc.empty, 1);
        check("rst max_add", ifc.max_add, 0);
        check("rst busy", ifc.busy, 0);
        check("rst search_done", ifc.search_done, 0);
        check("rst write_drop", ifc.write_drop, 0);
    endtask

    task automatic do_write(input string tag, input int a, input logic [31:0] k,
                            input int emax);
        ifc.cam_write_en = 1;
        ifc.write_addr   = 4'(a);
        ifc.write_key    = k;
        @(posedge clk); #1;
        ifc.cam_write_en = 0;
        model_write(a, k);
        check({tag, " max_add"}, ifc.max_add, emax);
        check({tag, " empty"}, ifc.empty, 0);
        check({tag, " write_drop"}, ifc.write_drop, 0);
    endtask

    // Issue one search (optionally with a same-edge write) and check it.
    task automatic do_search(input string tag, input logic [31:0] k,
                             input bit with_wr, input int wa, input logic [31:0] wk,
                             input bit em, input int ea, input int elat, input int emax);
        int n;
        int bcnt;
        ifc.cam_start  = 1;
        ifc.search_key = k;
        if (with_wr) begin
            ifc.cam_write_en = 1;
            ifc.write_addr   = 4'(wa);
            ifc.write_key    = wk;
        end
        @(posedge clk); #1;
        ifc.cam_start    = 0;
        ifc.cam_write_en = 0;
        n    = 1;
        bcnt = 0;
        while (!ifc.search_done && n < 40) begin
            if (ifc.busy) bcnt++;
            @(posedge clk); #1;
            n++;
        end
        check({tag, " search_done seen"}, ifc.search_done, 1);
        check({tag, " latency"}, n, elat);
        check({tag, " match"}, ifc.match, em);
        check({tag, " match_addr"}, ifc.match_addr, ea);
        check({tag, " max_add"}, ifc.max_add, emax);
        check({tag, " busy cycles before done"}, bcnt, elat - 1);
        check({tag, " busy at done"}, ifc.busy, 1);
        @(posedge clk); #1;
        check({tag, " done pulse width"}, ifc.search_done, 0);
        check({tag, " match held"}, ifc.match, em);
        check({tag, " busy after"}, ifc.busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit m;
        int a;
        int lat;
        int dones;
        int done_at;

        clk         = 0;
        rst         = 0;
        vectors     = 0;
        miscompares = 0;
        idle_inputs();
        model_reset();

        // Directed vectors with hand-derived expectations.
        tbl[0]  = '{OP_RST,  0, 32'h0,        0, 0, 0, 0};
        tbl[1]  = '{OP_SRCH, 0, 32'hDEADBEEF, 0, 0, 2, 0};
        tbl[2]  = '{OP_WR,   0, 32'h100,      0, 0, 0, 0};
        tbl[3]  = '{OP_WR,   1, 32'h101,      0, 0, 0, 1};
        tbl[4]  = '{OP_WR,   2, 32'h102,      0, 0, 0, 2};
        tbl[5]  = '{OP_WR,   3, 32'h103,      0, 0, 0, 3};
        tbl[6]  = '{OP_WR,   4, 32'h104,      0, 0, 0, 4};
        tbl[7]  = '{OP_WR,   5, 32'h105,      0, 0, 0, 5};
        tbl[8]  = '{OP_SRCH, 0, 32'h103,      1, 3, 5, 5};
        tbl[9]  = '{OP_SRCH, 0, 32'h999,      0, 0, 7, 5};
        tbl[10] = '{OP_RST,  0, 32'h0,        0, 0, 0, 0};
        tbl[11] = '{OP_WR,   2, 32'hAA,       0, 0, 0, 2};
        tbl[12] = '{OP_WR,   4, 32'hAA,       0, 0, 0, 4};
        tbl[13] = '{OP_SRCH, 0, 32'hAA,       1, 2, 4, 4};
        tbl[14] = '{OP_WR,   2, 32'hBB,       0, 0, 0, 4};
        tbl[15] = '{OP_SRCH, 0, 32'hAA,       1, 4, 6, 4};

        for (int i = 0; i < 16; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            case (tbl[i].op)
                OP_RST:  do_reset();
                OP_WR:   do_write(tag, tbl[i].addr, tbl[i].key, tbl[i].emax);
                default: do_search(tag, tbl[i].key, 0, 0, 0, tbl[i].em,
                                   tbl[i].ea, tbl[i].elat, tbl[i].emax);
            endcase
        end

        // Write and start during SCAN: write dropped, start ignored.
        do_reset();
        for (int i = 0; i < 6; i++) do_write("drop fill", i, 32'h100 + 32'(i), i);
        ifc.cam_start  = 1;
        ifc.search_key = 32'h999;
        @(posedge clk); #1;
        ifc.cam_start    = 1;
        ifc.search_key   = 32'h101;
        ifc.cam_write_en = 1;
        ifc.write_addr   = 4'd7;
        ifc.write_key    = 32'h777;
        dones   = 0;
        done_at = 0;
        @(posedge clk); #1;
        idle_inputs();
        check("drop pulse", ifc.write_drop, 1);
        for (int c = 3; c < 16; c++) begin
            @(posedge clk); #1;
            if (c == 3) check("drop pulse end", ifc.write_drop, 0);
            if (ifc.search_done) begin
                dones++;
                done_at = c;
                check("drop match", ifc.match, 0);
            end
        end
        check("drop done count", dones, 1);
        check("drop done cycle", done_at, 7);
        check("drop max_add", ifc.max_add, 5);
        do_search("drop addr7 unwritten", 32'h777, 0, 0, 0, 0, 0, 7, 5);

        // Same-edge write and search on an empty CAM.
        do_reset();
        model_write(0, 32'h55);
        do_search("same edge", 32'h55, 1, 0, 32'h55, 1, 0, 2, 0);

        // Reset in SCAN aborts with no search_done.
        do_reset();
        for (int i = 0; i < 6; i++) do_write("abort fill", i, 32'h100 + 32'(i), i);
        ifc.cam_start  = 1;
        ifc.search_key = 32'h999;
        @(posedge clk); #1;
        ifc.cam_start = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        check("abort busy", ifc.busy, 0);
        check("abort match", ifc.match, 0);
        check("abort empty", ifc.empty, 1);
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (ifc.search_done) dones++;
            @(posedge clk); #1;
        end
        check("abort no done", dones, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int it = 0; it < 300; it++) begin
            int r;
            int wa;
            logic [31:0] wk;
            logic [31:0] sk;
            r  = int'($urandom_range(0, 99));
            wa = int'($urandom_range(0, 15));
            wk = 32'h1000 + 32'($urandom_range(0, 7));
            sk = 32'h1000 + 32'($urandom_range(0, 9));
            if (r < 2) begin
                do_reset();
            end else if (r < 50) begin
                model_write(wa, wk);
                do_write("rand wr", wa, wk, mmax);
            end else if (r < 60) begin
                model_write(wa, wk);
                model_search(sk, m, a, lat);
                do_search("rand wr+srch", sk, 1, wa, wk, m, a, lat, mmax);
            end else begin
                model_search(sk, m, a, lat);
                do_search("rand srch", sk, 0, 0, 0, m, a, lat, mmax);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
